pb_conditioner: RTL and testbench

Front-end conditioner for the raw board pushbuttons, sitting directly upstream of the game controllers that consume `pb`. Each of N channels synchronises an asynchronous button input, debounces it with a per-channel state machine, and produces a clean level plus single-cycle press, release and long-hold pulses. The game logic and digit-stop counters can therefore count one event per physical press rather than edge-triggering on bouncing contacts.

---
 rtl/pb_pkg.sv | 19 +
 rtl/pb_channel.sv | 111 +++++++++++
 rtl/pb_conditioner.sv | 36 +++
 tb/tb_pb_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared types and helpers for the pushbutton conditioner: debounce FSM
// states and the counter-width rule used by each channel.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DOWN,
    DISARM
  } pb_state_t;

  // Bits needed to hold 0..n inclusive, never less than one.
  function automatic int cnt_width(input longint unsigned n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, debounce counter
// and hold counter. All outputs are registered; rel is the release pulse.
module pb_channel
  import pb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 50000000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam int HW = cnt_width(HOLD_CYC);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_FIRE = HW'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
  localparam bit            HOLD_EN   = (HOLD_CYC != 0);

  logic [1:0]    sync;
  logic          s;
  pb_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          level_d, press_d, rel_d, hold_d;

  assign s = sync[1];

  // NOTE: every flop in this block uses <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      hold    <= 1'b0;
    end else begin
      sync    <= {sync[0], pb ^ ACTIVE_LOW};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      level   <= level_d;
      press   <= press_d;
      rel     <= rel_d;
      hold    <= hold_d;
    end
  end

  // NOTE: hold-current-value defaults come first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          hcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!s) begin
          state_d = DISARM;
          cnt_d   = '0;
        end
        if (hcnt_q != HOLD_MAX) hcnt_d = hcnt_q + 1'b1;
      end
      DISARM: begin
        if (s) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (hcnt_q != HOLD_MAX) hcnt_d = hcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold fires only on the step into HOLD_FIRE (or on the press itself when
  // HOLD_CYC is 1); saturation then keeps it to one pulse per press.
  always_comb begin
    level_d = (state_d == DOWN) || (state_d == DISARM);
    press_d = (state_q == ARM) && (state_d == DOWN);
    rel_d   = (state_q == DISARM) && (state_d == IDLE);
    hold_d  = HOLD_EN && level_d && (hcnt_d == HOLD_FIRE) &&
              (press_d || (hcnt_d != hcnt_q));
  end

endmodule

// File: rtl/pb_conditioner.sv
// N independent pushbutton channels; rel carries the per-channel release
// pulse since "release" is a reserved word.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int unsigned N            = 1,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 50000000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pb,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] hold
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .pb   (pb[i]),
      .level(level[i]),
      .press(press[i]),
      .rel  (rel[i]),
      .hold (hold[i])
    );
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: a run-length reference model predicts every
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_pb_conditioner;

  localparam int N = 2;
  localparam int D = 4;
  localparam int H = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pb  = '1;
  logic [N-1:0] level, press, rel, hold;

  pb_conditioner #(
    .N(N), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pb   (pb),
    .level(level),
    .press(press),
    .rel  (rel),
    .hold (hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] hold;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_press[N], n_rel[N], n_hold[N];
  int   t_press[N], t_rel[N], t_hold[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for D+1 consecutive samples; hold counts cycles since the press.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int           m_run[N], m_hc[N];
  obs_t         m_exp;

  initial begin
    for (int ch = 0; ch < N; ch++) begin
      m_run[ch] = 0;
      m_hc[ch]  = 0;
      n_press[ch] = 0; n_rel[ch] = 0; n_hold[ch] = 0;
      t_press[ch] = -1; t_rel[ch] = -1; t_hold[ch] = -1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      m_exp = '0;
      if (rst) begin
        m_s1  = '0;
        m_s2  = '0;
        m_lvl = '0;
        for (int ch = 0; ch < N; ch++) begin
          m_run[ch] = 0;
          m_hc[ch]  = 0;
        end
      end else begin
        for (int ch = 0; ch < N; ch++) begin
          if (m_s2[ch] != m_lvl[ch]) m_run[ch]++;
          else                       m_run[ch] = 0;
          if (m_run[ch] == D + 1) begin
            m_run[ch] = 0;
            m_lvl[ch] = ~m_lvl[ch];
            if (m_lvl[ch]) begin
              m_exp.press[ch] = 1'b1;
              m_hc[ch] = 0;
              if (H == 1) m_exp.hold[ch] = 1'b1;
            end else begin
              m_exp.rel[ch] = 1'b1;
            end
          end else if (m_lvl[ch]) begin
            m_hc[ch]++;
            if (H > 0 && m_hc[ch] == H - 1) m_exp.hold[ch] = 1'b1;
          end
        end
        m_s2 = m_s1;
        m_s1 = ~pb;
      end
      m_exp.level = m_lvl;
      exp_q.push_back(m_exp);
    end
  end

  // Monitor: compares each registered output set and logs pulse times.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        check("outputs", 32'({level, press, rel, hold}), 32'(e));
        for (int ch = 0; ch < N; ch++) begin
          if (press[ch]) begin n_press[ch]++; t_press[ch] = cyc; end
          if (rel[ch])   begin n_rel[ch]++;   t_rel[ch]   = cyc; end
          if (hold[ch])  begin n_hold[ch]++;  t_hold[ch]  = cyc; end
        end
      end
    end
  end

  // Returns just after a negedge, once the monitor has logged that cycle.
  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int k, p0, r0, h0, p1;

  initial begin
    run(3);
    check("reset_state", 32'({level, press, rel, hold}), 32'd0);
    rst = 1'b0;
    run(5);

    // Clean press, then clean release
    p0 = n_press[0]; r0 = n_rel[0]; h0 = n_hold[0];
    k = cyc + 1;
    pb[0] = 1'b0;
    run(20);
    check("clean_press_count", n_press[0] - p0, 1);
    check("clean_press_time", t_press[0], k + 6);
    check("clean_level", 32'(level[0]), 1);
    check("clean_hold_count", n_hold[0] - h0, 1);
    check("clean_hold_time", t_hold[0], t_press[0] + 9);
    check("clean_no_release", n_rel[0] - r0, 0);
    check("clean_ch1_idle", n_press[1], 0);
    k = cyc + 1;
    pb[0] = 1'b1;
    run(10);
    check("clean_release_count", n_rel[0] - r0, 1);
    check("clean_release_time", t_rel[0], k + 6);
    check("clean_level_low", 32'(level[0]), 0);

    // Glitch shorter than the debounce window
    p0 = n_press[0]; r0 = n_rel[0];
    pb[0] = 1'b0;
    run(3);
    pb[0] = 1'b1;
    run(12);
    check("glitch_no_press", n_press[0] - p0, 0);
    check("glitch_no_release", n_rel[0] - r0, 0);

    // Contact bounce on release
    p0 = n_press[0]; r0 = n_rel[0];
    pb[0] = 1'b0;
    run(12);
    pb[0] = 1'b1;
    run(2);
    pb[0] = 1'b0;
    run(2);
    k = cyc + 1;
    pb[0] = 1'b1;
    run(12);
    check("bounce_press_count", n_press[0] - p0, 1);
    check("bounce_release_count", n_rel[0] - r0, 1);
    check("bounce_release_time", t_rel[0], k + 6);

    // Short press: no hold
    p0 = n_press[0]; r0 = n_rel[0]; h0 = n_hold[0];
    pb[0] = 1'b0;
    run(6);
    pb[0] = 1'b1;
    run(14);
    check("short_press_count", n_press[0] - p0, 1);
    check("short_release_count", n_rel[0] - r0, 1);
    check("short_no_hold", n_hold[0] - h0, 0);

    // Both channels fall on the same edge
    p0 = n_press[0]; p1 = n_press[1];
    k = cyc + 1;
    pb = '0;
    run(10);
    check("simul_press0_count", n_press[0] - p0, 1);
    check("simul_press1_count", n_press[1] - p1, 1);
    check("simul_press0_time", t_press[0], k + 6);
    check("simul_press1_time", t_press[1], k + 6);
    pb = '1;
    run(12);

    // Reset while held down
    pb[0] = 1'b0;
    run(10);
    p0 = n_press[0]; r0 = n_rel[0];
    rst = 1'b1;
    run(1);
    check("midreset_outputs", 32'({level, press, rel, hold}), 32'd0);
    rst = 1'b0;
    k = cyc + 1;
    run(10);
    check("midreset_repress_count", n_press[0] - p0, 1);
    check("midreset_repress_time", t_press[0], k + 6);
    check("midreset_no_release", n_rel[0] - r0, 0);
    pb[0] = 1'b1;
    run(12);

    // Randomised bouncing with occasional resets
    for (int i = 0; i < 400; i++) begin
      pb  = N'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      run($urandom_range(1, 14));
    end
    rst = 1'b0;
    pb  = '1;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
